// File: rtl/apb_traffic_ctrl_pkg.sv
// Shared types and constants for the APB traffic-light controller:
// light states, register offsets, CTL layout and timer-word field positions.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_e;

  localparam logic [31:0] REG_CTL      = 32'h000;
  localparam logic [31:0] REG_IRQ_STAT = 32'h004;
  localparam logic [31:0] REG_IRQ_EN   = 32'h008;
  localparam logic [31:0] CH_BASE      = 32'h100;

  localparam logic [3:0] OFS_TIMER0 = 4'h0;
  localparam logic [3:0] OFS_TIMER1 = 4'h4;
  localparam logic [3:0] OFS_STAT   = 4'h8;

  localparam int CTL_MOD_EN  = 0;
  localparam int CTL_BLINK_Y = 1;
  localparam int CTL_BLINK_R = 2;
  localparam int CTL_PROFILE = 3;

  typedef struct packed {
    logic profile;
    logic blink_red;
    logic blink_yellow;
    logic mod_en;
  } ctl_t;

  localparam int G2Y_LSB = 20;
  localparam int G2Y_W   = 12;
  localparam int R2G_LSB = 8;
  localparam int R2G_W   = 12;
  localparam int Y2R_LSB = 0;
  localparam int Y2R_W   = 8;
  localparam int CNT_W   = 12;

  localparam logic [31:0] TIMER0_RST = 32'hcafe_1234;
  localparam logic [31:0] TIMER1_RST = 32'hface_5678;

  function automatic logic [CNT_W-1:0] tfield(input logic [31:0] w, input int lsb, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return CNT_W'((w >> lsb) & mask);
  endfunction

endpackage

// File: rtl/apb_traffic_ctrl_if.sv
// APB bus bundle for the traffic controller; the slave modport faces the block.
interface apb_traffic_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_traffic_ctrl_ch.sv
// One intersection: light FSM, phase down-counter, blink phase and lamp decode.
// Advances only on the shared prescaler tick; frozen while a blink mode is active.
module traffic_ch
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  ctl_t             ctl,
  input  logic [31:0]      timer,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       lamp,
  output logic             red_entry
);

  localparam logic [1:0] S_OFF    = ST_OFF;
  localparam logic [1:0] S_RED    = ST_RED;
  localparam logic [1:0] S_GREEN  = ST_GREEN;
  localparam logic [1:0] S_YELLOW = ST_YELLOW;

  logic             blink;
  logic             phase;
  logic [CNT_W-1:0] g2y, r2g, y2r;

  assign g2y = tfield(timer, G2Y_LSB, G2Y_W);
  assign r2g = tfield(timer, R2G_LSB, R2G_W);
  assign y2r = tfield(timer, Y2R_LSB, Y2R_W);

  assign blink     = ctl.mod_en & (ctl.blink_red | ctl.blink_yellow);
  assign red_entry = ctl.mod_en & ~blink & tick & (state == S_YELLOW) & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      // held at 1 outside blink so the first blink cycle shows the lamp lit
      phase <= blink ? (phase ^ tick) : 1'b1;
      if (!ctl.mod_en) begin
        state <= S_OFF;
        cnt   <= '0;
      end else if (!blink) begin
        if (state == S_OFF) begin
          state <= S_RED;
          cnt   <= r2g;
        end else if (tick) begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            case (state)
              S_RED:   begin state <= S_GREEN;  cnt <= g2y; end
              S_GREEN: begin state <= S_YELLOW; cnt <= y2r; end
              default: begin state <= S_RED;    cnt <= r2g; end
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    lamp = 3'b000;
    if (ctl.mod_en) begin
      if (ctl.blink_red)         lamp[0] = phase;
      else if (ctl.blink_yellow) lamp[1] = phase;
      else begin
        case (state)
          S_RED:    lamp = 3'b001;
          S_GREEN:  lamp = 3'b100;
          S_YELLOW: lamp = 3'b010;
          default:  lamp = 3'b000;
        endcase
      end
    end
  end

endmodule

// File: rtl/apb_traffic_ctrl.sv
// APB-slave multi-intersection traffic-light controller with shared tick prescaler.
// Define TRAFFIC_PSLVERR_EN to flag unmapped / read-only / bad-channel accesses on pslverr.
module apb_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int PRESCALE = 1000,
  parameter int ADDR_W   = 12
) (
  input  logic                pclk,
  input  logic                preset,
  apb_traffic_ctrl_if.slave   apb,
  output logic [3*NUM_CH-1:0] lamp_o,
  output logic                irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  ctl_t                          ctl;
  logic [NUM_CH-1:0]             irq_stat, irq_en, red_entry;
  logic [NUM_CH-1:0][31:0]       timer0, timer1, timer_sel;
  logic [NUM_CH-1:0][1:0]        ch_state;
  logic [NUM_CH-1:0][CNT_W-1:0]  ch_cnt;
  logic [NUM_CH-1:0][2:0]        ch_lamp;

  logic [PW-1:0] pcnt;
  logic          tick;

  logic [31:0]       addr;
  logic [3:0]        ch_idx, ch_ofs;
  logic              hit_ctl, hit_stat, hit_en, ch_ok;
  logic [NUM_CH-1:0] ch_sel;
  logic              access, wr_en, rd_en;

  // ---- prescaler ----
  assign tick = ctl.mod_en & (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                  pcnt <= '0;
    else if (!ctl.mod_en || tick) pcnt <= '0;
    else                         pcnt <= pcnt + 1'b1;
  end

  // ---- address decode ----
  assign access = apb.psel & apb.penable;
  assign wr_en  = access & apb.pwrite;
  assign rd_en  = access & ~apb.pwrite;

  always_comb begin
    addr     = 32'(apb.paddr);
    ch_idx   = addr[7:4];
    ch_ofs   = addr[3:0];
    hit_ctl  = (addr == REG_CTL);
    hit_stat = (addr == REG_IRQ_STAT);
    hit_en   = (addr == REG_IRQ_EN);
    ch_ok    = (addr[31:8] == CH_BASE[31:8]) && (int'(ch_idx) < NUM_CH) &&
               (ch_ofs == OFS_TIMER0 || ch_ofs == OFS_TIMER1 || ch_ofs == OFS_STAT);
    for (int c = 0; c < NUM_CH; c++) ch_sel[c] = ch_ok && (int'(ch_idx) == c);
  end

  // ---- register file ----
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ctl      <= '0;
      irq_stat <= '0;
      irq_en   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        timer0[c] <= TIMER0_RST;
        timer1[c] <= TIMER1_RST;
      end
    end else begin
      // a red entry on the same edge as a W1C of that bit keeps the bit set
      irq_stat <= (irq_stat & ~((wr_en && hit_stat) ? apb.pwdata[NUM_CH-1:0] : '0)) | red_entry;
      if (wr_en) begin
        if (hit_ctl) ctl    <= ctl_t'(apb.pwdata[CTL_PROFILE:CTL_MOD_EN]);
        if (hit_en)  irq_en <= apb.pwdata[NUM_CH-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel[c] && ch_ofs == OFS_TIMER0) timer0[c] <= apb.pwdata;
          if (ch_sel[c] && ch_ofs == OFS_TIMER1) timer1[c] <= apb.pwdata;
        end
      end
    end
  end

  // ---- read mux ----
  always_comb begin
    apb.prdata = '0;
    if (rd_en) begin
      if (hit_ctl)  apb.prdata = {28'b0, ctl};
      if (hit_stat) apb.prdata = 32'(irq_stat);
      if (hit_en)   apb.prdata = 32'(irq_en);
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) begin
          case (ch_ofs)
            OFS_TIMER0: apb.prdata = timer0[c];
            OFS_TIMER1: apb.prdata = timer1[c];
            OFS_STAT:   apb.prdata = {4'b0, ch_cnt[c], 14'b0, ch_state[c]};
            default:    apb.prdata = '0;
          endcase
        end
      end
    end
  end

  assign apb.pready = 1'b1;

`ifdef TRAFFIC_PSLVERR_EN
  logic mapped, stat_wr;
  assign mapped      = hit_ctl | hit_stat | hit_en | ch_ok;
  assign stat_wr     = apb.pwrite & ch_ok & (ch_ofs == OFS_STAT);
  assign apb.pslverr = access & (~mapped | stat_wr);
`else
  assign apb.pslverr = 1'b0;
`endif

  // ---- channels ----
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign timer_sel[g] = ctl.profile ? timer1[g] : timer0[g];

    traffic_ch u_ch (
      .clk       (pclk),
      .rst       (preset),
      .tick      (tick),
      .ctl       (ctl),
      .timer     (timer_sel[g]),
      .state     (ch_state[g]),
      .cnt       (ch_cnt[g]),
      .lamp      (ch_lamp[g]),
      .red_entry (red_entry[g])
    );
  end

  assign lamp_o = ch_lamp;
  assign irq    = |(irq_stat & irq_en);

endmodule

// File: tb/tb_apb_traffic_ctrl.sv
// Randomized bench for apb_traffic_ctrl: a tick-level reference model predicts register
// reads (queued at issue, popped by a monitor), lamps, irq and pslverr every cycle.
module tb_apb_traffic_ctrl;

  localparam int NUM_CH   = 2;
  localparam int PRESCALE = 4;
  localparam int ADDR_W   = 12;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_traffic_ctrl_if #(.ADDR_W(ADDR_W)) apb ();
  logic [3*NUM_CH-1:0] lamp_o;
  logic                irq;

  apb_traffic_ctrl #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .preset(preset), .apb(apb), .lamp_o(lamp_o), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: phases measured in remaining ticks ----
  int              m_pcnt;
  bit [3:0]        m_ctl;
  bit [NUM_CH-1:0] m_stat, m_en;
  bit [31:0]       m_t0[NUM_CH], m_t1[NUM_CH];
  int              m_ph[NUM_CH];   // 0 off, 1 red, 2 green, 3 yellow
  int              m_left[NUM_CH]; // ticks left in current phase
  bit              m_bph[NUM_CH];
  bit [31:0]       expq[$];

  function automatic int dur(input bit [31:0] w, input int ph);
    if (ph == 1) return int'(w[19:8]) + 1;
    if (ph == 2) return int'(w[31:20]) + 1;
    return int'(w[7:0]) + 1;
  endfunction

  function automatic bit is_ch(input int a);
    return a >= 'h100 && a < 'h100 + 16 * NUM_CH && (a % 16 == 0 || a % 16 == 4 || a % 16 == 8);
  endfunction

  function automatic bit is_err(input int a, input bit wr);
`ifdef TRAFFIC_PSLVERR_EN
    if (is_ch(a)) return wr && (a % 16 == 8);
    return !(a == 0 || a == 4 || a == 8);
`else
    return 1'b0 & wr & (a != 0);
`endif
  endfunction

  function automatic bit [31:0] m_read(input int a);
    int c;
    if (a == 0) return 32'(m_ctl);
    if (a == 4) return 32'(m_stat);
    if (a == 8) return 32'(m_en);
    if (!is_ch(a)) return 32'h0;
    c = (a - 'h100) / 16;
    if (a % 16 == 0) return m_t0[c];
    if (a % 16 == 4) return m_t1[c];
    return 32'(((m_ph[c] == 0) ? 0 : m_left[c] - 1) * 65536 + m_ph[c]);
  endfunction

  function automatic bit [3*NUM_CH-1:0] exp_lamp();
    bit [3*NUM_CH-1:0] l = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_ctl[0]) begin
        if (m_ctl[2])      l[3*c]   = m_bph[c];
        else if (m_ctl[1]) l[3*c+1] = m_bph[c];
        else if (m_ph[c] == 1) l[3*c]   = 1'b1;
        else if (m_ph[c] == 2) l[3*c+2] = 1'b1;
        else if (m_ph[c] == 3) l[3*c+1] = 1'b1;
      end
    end
    return l;
  endfunction

  task automatic model_reset();
    m_pcnt = 0; m_ctl = '0; m_stat = '0; m_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_t0[c] = 32'hcafe_1234; m_t1[c] = 32'hface_5678;
      m_ph[c] = 0; m_left[c] = 0; m_bph[c] = 1'b1;
    end
  endtask

  task automatic model_step(input bit wr, input int a, input bit [31:0] wd);
    bit en, blink, tick;
    bit [NUM_CH-1:0] set;
    bit [31:0] w;
    en    = m_ctl[0];
    blink = en && (m_ctl[2] || m_ctl[1]);
    tick  = en && (m_pcnt == PRESCALE - 1);
    set   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w = m_ctl[3] ? m_t1[c] : m_t0[c];
      if (!en) begin
        m_ph[c] = 0; m_left[c] = 0;
      end else if (!blink) begin
        if (m_ph[c] == 0) begin
          m_ph[c] = 1; m_left[c] = dur(w, 1);
        end else if (tick) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            if (m_ph[c] == 3) set[c] = 1'b1;
            m_ph[c]   = (m_ph[c] == 3) ? 1 : m_ph[c] + 1;
            m_left[c] = dur(w, m_ph[c]);
          end
        end
      end
      m_bph[c] = blink ? (m_bph[c] ^ tick) : 1'b1;
    end
    m_pcnt = (!en || tick) ? 0 : m_pcnt + 1;
    m_stat = (m_stat & ~((wr && a == 4) ? wd[NUM_CH-1:0] : '0)) | set;
    if (wr) begin
      if (a == 0) m_ctl = wd[3:0];
      if (a == 8) m_en  = wd[NUM_CH-1:0];
      if (is_ch(a) && a % 16 == 0) m_t0[(a - 'h100) / 16] = wd;
      if (is_ch(a) && a % 16 == 4) m_t1[(a - 'h100) / 16] = wd;
    end
  endtask

  initial forever begin
    bit setup_rd;
    int a;
    @(posedge pclk or posedge preset);
    if (preset) begin
      model_reset();
      expq.delete();
    end else begin
      setup_rd = apb.psel && !apb.penable && !apb.pwrite;
      a        = int'(apb.paddr);
      model_step(apb.psel && apb.penable && apb.pwrite, a, apb.pwdata);
      if (setup_rd) expq.push_back(m_read(a));
    end
  end

  // ---- monitor ----
  initial forever begin
    @(negedge pclk);
    if (!preset) begin
      chk("lamp_o", 32'(lamp_o), 32'(exp_lamp()));
      chk("irq", 32'(irq), 32'(|(m_stat & m_en)));
      if (apb.psel && apb.penable) begin
        chk("pslverr", 32'(apb.pslverr), 32'(is_err(int'(apb.paddr), apb.pwrite)));
        if (!apb.pwrite) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL prdata: read at %h with no expected value queued", apb.paddr);
          end else begin
            chk($sformatf("prdata@%h", apb.paddr), apb.prdata, expq.pop_front());
          end
        end
      end else begin
        chk("prdata_idle", apb.prdata, 32'h0);
        chk("pslverr_idle", 32'(apb.pslverr), 32'h0);
      end
    end
  end

  // ---- driver ----
  task automatic xfer(input bit wr, input int a, input bit [31:0] wd);
    bit [31:0] av;
    av = 32'(a);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = av[ADDR_W-1:0]; apb.pwdata = wd;
    @(posedge pclk); #1 apb.penable = 1'b1;
    @(posedge pclk); #1 apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  function automatic bit [31:0] rand_timer();
    return ($urandom_range(0, 3) << 20) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 4);
  endfunction

  task automatic program_all();
    for (int c = 0; c < NUM_CH; c++) begin
      xfer(1, 'h100 + 16 * c, rand_timer());
      xfer(1, 'h104 + 16 * c, rand_timer());
    end
    xfer(1, 8, 32'h3);
    xfer(1, 0, 32'h1);
  endtask

  int rd_addrs[13] = '{'h000, 'h004, 'h008, 'h100, 'h104, 'h108, 'h110, 'h114, 'h118,
                       'h120, 'h10C, 'h300, 'h00C};

  initial begin
    int r, n;
    bit found;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    foreach (rd_addrs[i]) xfer(0, rd_addrs[i], 0);
    xfer(1, 'h10C, 32'hffff_ffff);
    xfer(1, 'h108, 32'hffff_ffff);
    xfer(1, 'h300, 32'h1);
    xfer(0, 'h108, 0);
    xfer(0, 'h000, 0);

    program_all();
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      xfer(0, rd_addrs[$urandom_range(0, 12)], 0);
      else if (r < 60) idle($urandom_range(1, 6));
      else if (r < 68) xfer(1, 0, {28'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0)});
      else if (r < 76) xfer(1, 4, $urandom_range(0, 3));
      else if (r < 84) xfer(1, 'h100 + 16 * $urandom_range(0, NUM_CH - 1) + 4 * $urandom_range(0, 1), rand_timer());
      else if (r < 88) xfer(1, 8, $urandom_range(0, 3));
      else             xfer(1, ($urandom_range(0, 1) == 1) ? 'h118 : 'h300, $urandom());
    end

    // asynchronous reset in the middle of a clock phase
    xfer(1, 0, 32'h1);
    idle(10);
    #2 preset = 1'b1;
    #1 chk("reset_lamp_async", 32'(lamp_o), 32'h0);
    chk("reset_irq_async", 32'(irq), 32'h0);
    @(posedge pclk); #1 preset = 1'b0;
    xfer(0, 'h100, 0);
    xfer(0, 'h104, 0);
    xfer(0, 'h000, 0);

    // W1C of bit 1 landing on the same edge that ch1 re-enters RED
    program_all();
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      if (m_ctl == 4'h1 && m_ph[1] == 3 && m_left[1] == 1 && m_pcnt == PRESCALE - 2) found = 1'b1;
      else begin idle(1); n++; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL w1c_race: ch1 never reached the end of YELLOW within %0d cycles", n);
    end else begin
      xfer(1, 4, 32'h2);
      chk("w1c_race_irq", 32'(irq), 32'h1);
      xfer(0, 4, 0);
    end

    idle(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
